// File: rtl/i2c_codec_pkg.sv
// i2c_codec_pkg: shared constants for the codec control-port I2C target.
//   DEV_ADDR_DEFAULT : 7-bit device address the codec answers to
//   state_t / S_*    : target FSM state encoding
//   codec_reg_e      : codec register map (register address field of a write)
package i2c_codec_pkg;

   localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE     = 3'd0;
   localparam state_t S_DEV      = 3'd1;
   localparam state_t S_ACK_DEV  = 3'd2;
   localparam state_t S_REG      = 3'd3;
   localparam state_t S_ACK_REG  = 3'd4;
   localparam state_t S_DATA     = 3'd5;
   localparam state_t S_ACK_DATA = 3'd6;
   localparam state_t S_IGNORE   = 3'd7;

   typedef enum logic [6:0] {
      REG_LINVOL = 7'h00,
      REG_RINVOL = 7'h01,
      REG_LHPOUT = 7'h02,
      REG_RHPOUT = 7'h03,
      REG_APANA  = 7'h04,
      REG_DPATH  = 7'h05,
      REG_PWR    = 7'h06,
      REG_DAIF   = 7'h07,
      REG_SRATE  = 7'h08,
      REG_ACTIVE = 7'h09,
      REG_RESET  = 7'h0F
   } codec_reg_e;

endpackage

// File: rtl/i2c_codec_target_sync.sv
// i2c_bus_sync: brings SCL/SDA into the clk domain and decodes bus events.
//   clk_i, rst_ni      : system clock, async active-low reset
//   scl_i, sda_i       : raw bus lines
//   scl_rise_o/fall_o  : one-cycle pulses on synchronised SCL edges
//   start_o / stop_o   : one-cycle pulses for START / STOP conditions
//   sda_o              : synchronised SDA, aligned with the event pulses
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o,
   output logic sda_o
);

   logic [SYNC_STAGES-1:0] scl_q, sda_q;
   logic scl_h_q, sda_h_q, rise_q, fall_q, start_q, stop_q;
   logic scl_s, sda_s;

   assign scl_s = scl_q[SYNC_STAGES-1];
   assign sda_s = sda_q[SYNC_STAGES-1];

   // Lines idle high, so the chain resets high to avoid a false edge after reset.
   // Event pulses are registered; sda_h_q is SDA delayed by the same amount.
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         scl_q   <= '1;
         sda_q   <= '1;
         scl_h_q <= 1'b1;
         sda_h_q <= 1'b1;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         start_q <= 1'b0;
         stop_q  <= 1'b0;
      end else begin
         scl_q   <= (scl_q << 1) | SYNC_STAGES'(scl_i);
         sda_q   <= (sda_q << 1) | SYNC_STAGES'(sda_i);
         scl_h_q <= scl_s;
         sda_h_q <= sda_s;
         rise_q  <= scl_s & ~scl_h_q;
         fall_q  <= ~scl_s & scl_h_q;
         start_q <= scl_s & scl_h_q & sda_h_q & ~sda_s;
         stop_q  <= scl_s & scl_h_q & ~sda_h_q & sda_s;
      end

   assign scl_rise_o = rise_q;
   assign scl_fall_o = fall_q;
   assign start_o    = start_q;
   assign stop_o     = stop_q;
   assign sda_o      = sda_h_q;

endmodule

// File: rtl/i2c_codec_target.sv
// i2c_codec_target: write-only I2C target for the codec control port.
//   clk      : system clock
//   reset    : async active-low reset
//   scl      : bus clock
//   sda_i    : bus data as seen on the wire
//   sda_oe   : 1 pulls SDA low (ACK)
//   wr_valid : one-cycle strobe per completed, ACKed register write
//   wr_addr  : register address of the last write (held)
//   wr_data  : 9-bit register data of the last write (held)
//   err      : one-cycle strobe on abort / NACKed read / extra byte
//   busy     : high from START to STOP
module i2c_codec_target
   import i2c_codec_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEFAULT,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic       wr_valid,
   output logic [6:0] wr_addr,
   output logic [8:0] wr_data,
   output logic       err,
   output logic       busy
);

   logic rise, fall, start, stop, sda;

   i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i      (clk),
      .rst_ni     (reset),
      .scl_i      (scl),
      .sda_i      (sda_i),
      .scl_rise_o (rise),
      .scl_fall_o (fall),
      .start_o    (start),
      .stop_o     (stop),
      .sda_o      (sda)
   );

   state_t     state_q, state_d;
   logic [7:0] sr_q, sr_d;
   logic [3:0] cnt_q, cnt_d;
   logic [6:0] addr_q, addr_d, wa_q, wa_d;
   logic [8:0] wd_q, wd_d;
   logic       d8_q, d8_d, oe_q, oe_d, wv_q, wv_d, err_q, err_d, busy_q, busy_d;
   // matched_q: device byte ACKed and the write is not yet complete.
   // wrote_q: write completed, a further byte still owes one err pulse.
   logic       matched_q, matched_d, wrote_q, wrote_d;
   logic       full;

   assign full = cnt_q == 4'd8;

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      d8_d      = d8_q;
      wa_d      = wa_q;
      wd_d      = wd_q;
      oe_d      = oe_q;
      busy_d    = busy_q;
      matched_d = matched_q;
      wrote_d   = wrote_q;
      wv_d      = 1'b0;
      err_d     = 1'b0;
      if (stop) begin
         if (state_q != S_IDLE) begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            oe_d      = 1'b0;
            cnt_d     = 4'd0;
            err_d     = matched_q;
            matched_d = 1'b0;
            wrote_d   = 1'b0;
         end
      end else if (start) begin
         state_d   = S_DEV;
         busy_d    = 1'b1;
         oe_d      = 1'b0;
         cnt_d     = 4'd0;
         err_d     = matched_q;
         matched_d = 1'b0;
         wrote_d   = 1'b0;
      end else if (rise) begin
         if ((state_q == S_DEV || state_q == S_REG || state_q == S_DATA) && !full) begin
            sr_d  = {sr_q[6:0], sda};
            cnt_d = cnt_q + 4'd1;
         end else if (state_q == S_IGNORE && cnt_q < 4'd9) begin
            cnt_d = cnt_q + 4'd1;
         end
      end else if (fall) begin
         // ACK states are entered on a fall, so the next fall ends the 9th pulse.
         case (state_q)
            S_DEV: if (full) begin
               if (sr_q == {DEV_ADDR, 1'b0}) begin
                  state_d   = S_ACK_DEV;
                  oe_d      = 1'b1;
                  cnt_d     = 4'd0;
                  matched_d = 1'b1;
               end else begin
                  // 8 of 9 clocks of this byte seen; the NACK clock completes it.
                  state_d = S_IGNORE;
                  err_d   = sr_q[7:1] == DEV_ADDR;
               end
            end
            S_ACK_DEV: begin
               state_d = S_REG;
               oe_d    = 1'b0;
            end
            S_REG: if (full) begin
               state_d = S_ACK_REG;
               addr_d  = sr_q[7:1];
               d8_d    = sr_q[0];
               oe_d    = 1'b1;
               cnt_d   = 4'd0;
            end
            S_ACK_REG: begin
               state_d = S_DATA;
               oe_d    = 1'b0;
            end
            S_DATA: if (full) begin
               state_d   = S_ACK_DATA;
               oe_d      = 1'b1;
               cnt_d     = 4'd0;
               wv_d      = 1'b1;
               wa_d      = addr_q;
               wd_d      = {d8_q, sr_q};
               matched_d = 1'b0;
               wrote_d   = 1'b1;
            end
            S_ACK_DATA: begin
               state_d = S_IGNORE;
               oe_d    = 1'b0;
               cnt_d   = 4'd0;
            end
            S_IGNORE: begin
               err_d   = full & wrote_q;
               wrote_d = wrote_q & ~full;
               cnt_d   = cnt_q == 4'd9 ? 4'd0 : cnt_q;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q   <= S_IDLE;
         sr_q      <= 8'd0;
         cnt_q     <= 4'd0;
         addr_q    <= 7'd0;
         d8_q      <= 1'b0;
         wa_q      <= 7'd0;
         wd_q      <= 9'd0;
         oe_q      <= 1'b0;
         wv_q      <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         matched_q <= 1'b0;
         wrote_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         d8_q      <= d8_d;
         wa_q      <= wa_d;
         wd_q      <= wd_d;
         oe_q      <= oe_d;
         wv_q      <= wv_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         matched_q <= matched_d;
         wrote_q   <= wrote_d;
      end

   assign sda_oe   = oe_q;
   assign wr_valid = wv_q;
   assign wr_addr  = wa_q;
   assign wr_data  = wd_q;
   assign err      = err_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_codec_target.sv
// tb_i2c_codec_target: bus-level master driving the codec I2C target.
module tb_i2c_codec_target;
   import i2c_codec_pkg::*;

   localparam int H = 10;
   localparam int SS = 2;
   localparam logic [6:0] DEV = 7'h1A;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic scl = 1'b1;
   logic sda_m = 1'b1;
   logic sda_bus, sda_oe, wr_valid, err, busy;
   logic [6:0] wr_addr;
   logic [8:0] wr_data;

   always #5 clk = ~clk;
   assign sda_bus = sda_m & ~sda_oe;

   i2c_codec_target #(.DEV_ADDR(DEV), .SYNC_STAGES(SS)) dut (
      .clk      (clk),
      .reset    (reset),
      .scl      (scl),
      .sda_i    (sda_bus),
      .sda_oe   (sda_oe),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .err      (err),
      .busy     (busy)
   );

   int wv_cnt = 0, err_cnt = 0, both_cnt = 0;
   always @(negedge clk) begin
      if (wr_valid) wv_cnt <= wv_cnt + 1;
      if (err) err_cnt <= err_cnt + 1;
      if (wr_valid && err) both_cnt <= both_cnt + 1;
   end

   int checks = 0, errors = 0;
   logic [6:0] prev_a = 7'd0;
   logic [8:0] prev_d = 9'd0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_cond();
      sda_m = 1'b0;
      cyc(H);
      scl = 1'b0;
   endtask

   task automatic stop_cond();
      cyc(2);
      sda_m = 1'b0;
      cyc(H - 2);
      scl = 1'b1;
      cyc(H);
      sda_m = 1'b1;
      cyc(H);
   endtask

   task automatic restart_cond();
      cyc(2);
      sda_m = 1'b1;
      cyc(H - 2);
      scl = 1'b1;
      cyc(H);
      sda_m = 1'b0;
      cyc(H);
      scl = 1'b0;
   endtask

   task automatic bits_out(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         cyc(2);
         sda_m = b[7];
         b = b << 1;
         cyc(H - 2);
         scl = 1'b1;
         cyc(H);
         scl = 1'b0;
      end
   endtask

   task automatic ack_clk(output logic ack);
      cyc(2);
      sda_m = 1'b1;
      cyc(H - 2);
      scl = 1'b1;
      cyc(H / 2);
      ack = ~sda_bus;
      cyc(H / 2);
      scl = 1'b0;
   endtask

   task automatic run(input string tag, input logic [31:0] b, input int n, output logic [3:0] ackm);
      logic a;
      logic [31:0] s;
      s = b;
      ackm = 4'd0;
      start_cond();
      chk({tag, " busy_on"}, busy, 1);
      for (int i = 0; i < n; i++) begin
         bits_out(s[31:24]);
         s = s << 8;
         ack_clk(a);
         ackm = ackm | (a ? (4'd1 << i) : 4'd0);
      end
      stop_cond();
   endtask

   task automatic do_txn(input string tag, input logic [31:0] b, input int n, input logic [3:0] eack,
                         input int ewv, input logic [6:0] ea, input logic [8:0] ed, input int ee);
      int w0, e0, b0;
      logic [3:0] ackm;
      w0 = wv_cnt;
      e0 = err_cnt;
      b0 = both_cnt;
      run(tag, b, n, ackm);
      if (ewv == 0) begin
         ea = prev_a;
         ed = prev_d;
      end
      chk({tag, " acks"}, ackm, eack);
      chk({tag, " wr_valid_count"}, wv_cnt - w0, ewv);
      chk({tag, " wr_addr"}, wr_addr, ea);
      chk({tag, " wr_data"}, wr_data, ed);
      chk({tag, " err_count"}, err_cnt - e0, ee);
      chk({tag, " busy_off"}, busy, 0);
      chk({tag, " valid_err_overlap"}, both_cnt - b0, 0);
      prev_a = ea;
      prev_d = ed;
   endtask

   // Reference: what a write-only 3-byte codec target must do for a START ... STOP
   // carrying n bytes.
   task automatic model(input logic [31:0] b, input int n, output logic [3:0] ack, output int wv,
                        output logic [6:0] a, output logic [8:0] d, output int e);
      logic [7:0] b0, b1, b2;
      logic ok;
      {b0, b1, b2} = b[31:8];
      ok = b0 == {DEV, 1'b0};
      ack = 4'd0;
      wv = 0;
      a = 7'd0;
      d = 9'd0;
      e = (!ok && b0[7:1] == DEV) ? 1 : 0;
      if (ok) begin
         ack = n >= 3 ? 4'b0111 : n == 2 ? 4'b0011 : 4'b0001;
         if (n >= 3) begin
            wv = 1;
            a = b1[7:1];
            d = {b1[0], b2};
         end
         e = (n != 3) ? 1 : 0;
      end
   endtask

   typedef struct {
      logic [31:0] b;
      int          n;
      logic [3:0]  ack;
      int          wv;
      logic [6:0]  a;
      logic [8:0]  d;
      int          e;
   } vec_t;

   vec_t tab [10];

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      logic a;
      logic [3:0] ackm, eack;
      int k, w0, e0, ewv, ee;
      logic [6:0] ea;
      logic [8:0] ed;
      logic [31:0] rb;
      logic [7:0] fb;

      tab[0] = '{32'h34081200, 3, 4'b0111, 1, 7'h04, 9'h012, 0};
      tab[1] = '{32'h340F0000, 3, 4'b0111, 1, 7'h07, 9'h100, 0};
      tab[2] = '{32'h36081200, 3, 4'b0000, 0, 7'h00, 9'h000, 0};
      tab[3] = '{32'h35081200, 3, 4'b0000, 0, 7'h00, 9'h000, 1};
      tab[4] = '{32'h34080000, 2, 4'b0011, 0, 7'h00, 9'h000, 1};
      tab[5] = '{32'h341E5500, 3, 4'b0111, 1, REG_RESET, 9'h055, 0};
      tab[6] = '{32'h34081277, 4, 4'b0111, 1, 7'h04, 9'h012, 1};
      tab[7] = '{32'h34000000, 1, 4'b0001, 0, 7'h00, 9'h000, 1};
      tab[8] = '{32'h34FFFF00, 3, 4'b0111, 1, 7'h7F, 9'h1FF, 0};
      tab[9] = '{32'h00081200, 3, 4'b0000, 0, 7'h00, 9'h000, 0};

      cyc(3);
      chk("rst sda_oe", sda_oe, 0);
      chk("rst wr_valid", wr_valid, 0);
      chk("rst wr_addr", wr_addr, 0);
      chk("rst wr_data", wr_data, 0);
      chk("rst err", err, 0);
      chk("rst busy", busy, 0);
      reset = 1'b1;
      cyc(5);
      chk("post_rst busy", busy, 0);

      for (int i = 0; i < 10; i++)
         do_txn($sformatf("vec%0d", i), tab[i].b, tab[i].n, tab[i].ack, tab[i].wv, tab[i].a, tab[i].d, tab[i].e);

      // ACK drive/release latency relative to the bus SCL falling edge
      w0 = wv_cnt;
      start_cond();
      bits_out(8'h34);
      k = 0;
      while (!sda_oe && k < 12) begin
         cyc(1);
         k++;
         if (k == 2) sda_m = 1'b1;
      end
      chk("oe_assert_delay", k, SS + 2);
      cyc(H - k);
      scl = 1'b1;
      cyc(H / 2);
      chk("ack_dev_mid_high", sda_oe, 1);
      cyc(H / 2);
      chk("ack_dev_end_high", sda_oe, 1);
      scl = 1'b0;
      k = 0;
      while (sda_oe && k < 12) begin
         cyc(1);
         k++;
      end
      chk("oe_release_delay", k, SS + 2);
      bits_out(8'h08);
      ack_clk(a);
      chk("lat reg ack", a, 1);
      bits_out(8'h12);
      ack_clk(a);
      chk("lat data ack", a, 1);
      stop_cond();
      chk("lat wr_valid_count", wv_cnt - w0, 1);
      chk("lat wr_data", wr_data, 9'h012);
      prev_a = 7'h04;
      prev_d = 9'h012;

      // Repeated START after a matched device byte discards the partial write
      w0 = wv_cnt;
      e0 = err_cnt;
      ackm = 4'd0;
      start_cond();
      bits_out(8'h34);
      ack_clk(a);
      ackm[0] = a;
      restart_cond();
      bits_out(8'h34);
      ack_clk(a);
      ackm[1] = a;
      bits_out(8'h0E);
      ack_clk(a);
      ackm[2] = a;
      bits_out(8'h4A);
      ack_clk(a);
      ackm[3] = a;
      stop_cond();
      chk("rs acks", ackm, 4'b1111);
      chk("rs wr_valid_count", wv_cnt - w0, 1);
      chk("rs wr_addr", wr_addr, 7'h07);
      chk("rs wr_data", wr_data, 9'h04A);
      chk("rs err_count", err_cnt - e0, 1);
      prev_a = 7'h07;
      prev_d = 9'h04A;

      // Async reset while holding the register-byte ACK
      start_cond();
      bits_out(8'h34);
      ack_clk(a);
      bits_out(8'h08);
      cyc(2);
      sda_m = 1'b1;
      cyc(H - 2);
      scl = 1'b1;
      cyc(H / 2);
      chk("ar oe_before", sda_oe, 1);
      #2 reset = 1'b0;
      #1;
      chk("ar oe_async", sda_oe, 0);
      chk("ar busy", busy, 0);
      chk("ar wr_addr", wr_addr, 0);
      cyc(2);
      reset = 1'b1;
      cyc(H / 2);
      scl = 1'b0;
      cyc(H);
      scl = 1'b1;
      cyc(H);
      prev_a = 7'd0;
      prev_d = 9'd0;
      do_txn("after_reset", 32'h34081200, 3, 4'b0111, 1, 7'h04, 9'h012, 0);

      for (int r = 0; r < 30; r++) begin
         k = $urandom_range(0, 5);
         fb = k < 3 ? 8'h34 : k == 3 ? 8'h35 : k == 4 ? 8'h36 : 8'($urandom);
         rb = {fb, 24'($urandom)};
         k = $urandom_range(1, 4);
         model(rb, k, eack, ewv, ea, ed, ee);
         do_txn($sformatf("rnd%0d", r), rb, k, eack, ewv, ea, ed, ee);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_codec_target.md
Name: i2c_codec_target

Overview:
- I2C target (responder) for the codec control port: the receiving end of the write-only 3-byte transactions issued by the existing i2c configuration master.
- Decodes device address, register address and 9-bit data, ACKs each byte on SDA and emits one write strobe per completed register write.
- Used as the codec-side model in the recorder benches, and as a register-snoop tap on the board.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit device address this target answers to.
- SYNC_STAGES, 2, flip-flop synchroniser depth on SCL and SDA.

Ports:
- clk  input  1  system clock (12 MHz domain); SCL low phase must last at least SYNC_STAGES+4 clk cycles.
- reset  input  1  asynchronous, active-low reset.
- scl  input  1  I2C clock from the bus.
- sda_i  input  1  I2C data as seen on the bus.
- sda_oe  output  1  1 = pull SDA low (ACK); 0 = release.
- wr_valid  output  1  one-cycle strobe: register write completed and ACKed.
- wr_addr  output  7  register address of the last write; held until the next strobe.
- wr_data  output  9  register data of the last write; held.
- err  output  1  one-cycle strobe: transaction aborted or NACKed.
- busy  output  1  high from START to STOP.

Behaviour:
- Reset (reset=0): all outputs 0, state IDLE, shift register cleared. Async assertion releases sda_oe immediately, including mid-ACK.
- Synchronise scl and sda_i through SYNC_STAGES flops, then one history flop. Detect:
  - scl_rise and scl_fall;
  - START = SDA falls while SCL high;
  - STOP = SDA rises while SCL high.
- Sample data bits on scl_rise, MSB first, into an 8-bit shift register with a 4-bit bit counter.
- States: IDLE, DEV, ACK_DEV, REG, ACK_REG, DATA, ACK_DATA, IGNORE.
- IDLE: START -> DEV, busy=1.
- DEV: after the 8th scl_rise, compare byte[7:1] with DEV_ADDR and byte[0] with 0 (write).
  - Match: at the next scl_fall go to ACK_DEV and set sda_oe=1.
  - Mismatch, or R/W=1: go to IGNORE with sda_oe=0. Pulse err only on the R/W=1 case with a matching address.
- ACK_DEV / ACK_REG: hold sda_oe=1 through the 9th SCL pulse. Release on the following scl_fall, then enter REG or DATA respectively.
- REG: after 8 bits, latch addr_q = byte[7:1] and d8_q = byte[0]; go to ACK_REG.
- DATA: after 8 bits, go to ACK_DATA.
- ACK_DATA: on the scl_fall that asserts the ACK, pulse wr_valid with:
  - wr_addr = addr_q;
  - wr_data = {d8_q, byte}.
  - The next scl_fall releases sda_oe and enters IGNORE.
- IGNORE: sda_oe=0. Additional bytes are not ACKed; a 4th byte in the same transaction pulses err once.
- sda_oe timing: asserts and deasserts SYNC_STAGES+2 clk cycles after the bus SCL falling edge. It never changes while synchronised SCL is high.
- STOP in any state: go to IDLE, busy=0, sda_oe=0.
  - Pulse err if the STOP arrives before ACK_DATA completed and at least the device byte matched.
  - STOP in IDLE is ignored.
- Repeated START in any non-IDLE state: go to DEV, clear the bit counter, sda_oe=0.
  - Partial write is discarded: no wr_valid, err pulse if the address had matched.
- START and STOP cannot occur in the same cycle; STOP has priority if both are decoded.
- wr_valid and err are never asserted in the same cycle.
- busy goes high the cycle after the START is detected.
- Register address is not range-checked; 0x0F (codec reset) is passed through like any other register.

Decomposition:
- Package i2c_codec_pkg:
  - state enum;
  - DEV_ADDR default 7'h1A;
  - codec register address constants (LINVOL=0x00 .. ACTIVE=0x09, RESET=0x0F).
- Sub-module i2c_bus_sync: synchronisers, edge history, and the scl_rise/scl_fall/start/stop pulses. The FSM stays in the top.

Test Plan:
- Write bytes 0x34, 0x08, 0x12 then STOP -> ACK on all three bytes; single wr_valid with wr_addr=0x04, wr_data=0x012; err=0; busy falls after STOP.
- Write bytes 0x34, 0x0F, 0x00 (reg 0x07 data 0x100) -> wr_addr=0x07, wr_data=0x100.
- Device byte 0x36 -> no ACK (sda_oe stays 0), no wr_valid, no err; remaining bytes ignored.
- Device byte 0x35 (read) -> NACK, err pulses once.
- Send 0x34, 0x08, then STOP -> err pulses once, no wr_valid, busy=0.
- Send 0x34, then repeated START, then 0x34, 0x0E, 0x4A -> exactly one wr_valid with addr=0x07, data=0x04A.
- Assert reset during ACK_REG -> sda_oe drops asynchronously; the next full transaction completes normally.
